// File: rtl/spislaveio_if.sv
// CPU-side register bus of the SPI target: register select, write/read data,
// access strobe and the level interrupt back to the CPU.
interface spislaveio_if;
    logic [2:0] AD;
    logic [7:0] DI;
    logic [7:0] DO;
    logic       rw;
    logic       cs;
    logic       irq;

    modport master (output AD, DI, rw, cs, input DO, irq);
    modport slave  (input AD, DI, rw, cs, output DO, irq);
endinterface

// File: rtl/spislaveio.sv
// SPI mode-0 target with a CPU register interface: synchronized SPI pins,
// one-byte RX buffer with overrun flag, one-byte TX holding register and IRQ.
module spislaveio (
    input  logic        clk,
    input  logic        rst,
    spislaveio_if.slave bus,
    input  logic        ssel,
    input  logic        sck,
    input  logic        mosi,
    output logic        miso,
    output logic        miso_oe
);
    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t      r_state;
    state_t      w_stateNext;
    logic        w_enter;
    logic        w_shifting;

    logic        r_sselMeta, r_sselSync, r_sselPrev;
    logic        r_sckMeta, r_sckSync, r_sckPrev;
    logic        r_mosiMeta, r_mosiSync;

    logic [2:0]  r_bitCnt;
    logic [7:0]  r_rxShift;
    logic [7:0]  r_rxData;
    logic [7:0]  r_txHold;
    logic [7:0]  r_txShift;
    logic        r_rxf, r_ovr, r_txe;
    logic        r_en, r_rxie, r_txie;
    logic        r_irq;

    logic        w_sselFall, w_sselRise, w_sckRise, w_sckFall;
    logic        w_wr, w_wrData, w_wrStatus, w_wrCtrl, w_rdData, w_disable;
    logic        w_byteDone, w_txReload, w_rxfEff;
    logic [7:0]  w_rxByte;
    logic [7:0]  w_status;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sselMeta <= 1'b1;
            r_sselSync <= 1'b1;
            r_sselPrev <= 1'b1;
            r_sckMeta  <= 1'b0;
            r_sckSync  <= 1'b0;
            r_sckPrev  <= 1'b0;
            r_mosiMeta <= 1'b0;
            r_mosiSync <= 1'b0;
        end else begin
            r_sselMeta <= ssel;
            r_sselSync <= r_sselMeta;
            r_sselPrev <= r_sselSync;
            r_sckMeta  <= sck;
            r_sckSync  <= r_sckMeta;
            r_sckPrev  <= r_sckSync;
            r_mosiMeta <= mosi;
            r_mosiSync <= r_mosiMeta;
        end
    end

    assign w_sselFall = r_sselPrev & ~r_sselSync;
    assign w_sselRise = ~r_sselPrev & r_sselSync;
    assign w_sckRise  = ~r_sckPrev & r_sckSync;
    assign w_sckFall  = r_sckPrev & ~r_sckSync;

    assign w_wr       = bus.cs & ~bus.rw;
    assign w_wrData   = w_wr & (bus.AD == 3'd0);
    assign w_wrStatus = w_wr & (bus.AD == 3'd1);
    assign w_wrCtrl   = w_wr & (bus.AD == 3'd2);
    assign w_rdData   = bus.cs & bus.rw & (bus.AD == 3'd0);
    assign w_disable  = w_wrCtrl & ~bus.DI[0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Leaving SHIFT suppresses any sck edge seen in the same cycle.
    always_comb begin
        w_stateNext = r_state;
        w_enter     = 1'b0;
        w_shifting  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_sselFall && r_en) begin
                    w_stateNext = SHIFT;
                    w_enter     = 1'b1;
                end
            end
            SHIFT: begin
                if (w_sselRise || w_disable) begin
                    w_stateNext = IDLE;
                end else begin
                    w_shifting = 1'b1;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    assign w_rxByte   = {r_rxShift[6:0], r_mosiSync};
    assign w_byteDone = w_shifting & w_sckRise & (r_bitCnt == 3'd7);
    assign w_txReload = w_enter | (w_shifting & w_sckFall & (r_bitCnt == 3'd0));
    assign w_rxfEff   = r_rxf & ~w_rdData;

    // A CPU DATA write lands after a coincident reload; a DATA read frees the buffer for a coincident byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bitCnt  <= 3'd0;
            r_rxShift <= 8'h00;
            r_rxData  <= 8'h00;
            r_txHold  <= 8'h00;
            r_txShift <= 8'hFF;
            r_rxf     <= 1'b0;
            r_ovr     <= 1'b0;
            r_txe     <= 1'b1;
            r_en      <= 1'b0;
            r_rxie    <= 1'b0;
            r_txie    <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            if (w_enter) begin
                r_bitCnt <= 3'd0;
            end else if (w_shifting && w_sckRise) begin
                r_rxShift <= w_rxByte;
                r_bitCnt  <= r_bitCnt + 3'd1;
            end

            if (w_txReload) begin
                r_txShift <= r_txe ? 8'hFF : r_txHold;
            end else if (w_shifting && w_sckFall) begin
                r_txShift <= {r_txShift[6:0], 1'b0};
            end

            if (w_wrData) begin
                r_txHold <= bus.DI;
                r_txe    <= 1'b0;
            end else if (w_txReload) begin
                r_txe    <= 1'b1;
            end

            if (w_byteDone && !w_rxfEff) begin
                r_rxData <= w_rxByte;
                r_rxf    <= 1'b1;
            end else if (w_rdData) begin
                r_rxf    <= 1'b0;
            end

            if (w_byteDone && w_rxfEff) begin
                r_ovr <= 1'b1;
            end else if (w_wrStatus && bus.DI[2]) begin
                r_ovr <= 1'b0;
            end

            if (w_wrCtrl) begin
                r_en   <= bus.DI[0];
                r_rxie <= bus.DI[1];
                r_txie <= bus.DI[2];
            end

            r_irq <= r_en & ((r_rxie & (r_rxf | r_ovr)) | (r_txie & r_txe));
        end
    end

    assign w_status = {r_irq, 3'b000, ~r_sselSync, r_ovr, r_txe, r_rxf};

    always_comb begin
        bus.DO = 8'h00;
        if (bus.cs) begin
            case (bus.AD)
                3'd0:    bus.DO = r_rxData;
                3'd1:    bus.DO = w_status;
                3'd2:    bus.DO = {5'b00000, r_txie, r_rxie, r_en};
                default: bus.DO = 8'h00;
            endcase
        end
    end

    assign bus.irq = r_irq;
    assign miso    = r_txShift[7];
    assign miso_oe = (r_state == SHIFT) & ~r_sselSync;
endmodule

// File: tb/tb_spislaveio.sv
// Randomized scoreboard bench for spislaveio: a byte-level register/transfer model
// queues expected CPU reads and controller-side miso bytes for a decoupled monitor.
module tb_spislaveio;
    localparam int HALF = 4;

    logic clk = 1'b0;
    logic rst;
    logic ssel, sck, mosi, miso, miso_oe;

    always #5 clk = ~clk;

    spislaveio_if bus();

    spislaveio dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .ssel    (ssel),
        .sck     (sck),
        .mosi    (mosi),
        .miso    (miso),
        .miso_oe (miso_oe)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] readQ[$];
    logic [7:0] misoQ[$];

    logic [7:0] mRxData, mTxHold, mTxNext;
    logic       mRxf, mOvr, mTxe, mEn, mRxie, mTxie, mSsel;

    logic [7:0] misoShift = 8'h00;
    int         misoCnt = 0;
    logic       sckPrev = 1'b0;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s got %02h expected %02h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        mRxData = 8'h00;
        mTxHold = 8'h00;
        mTxNext = 8'hFF;
        mRxf    = 1'b0;
        mOvr    = 1'b0;
        mTxe    = 1'b1;
        mEn     = 1'b0;
        mRxie   = 1'b0;
        mTxie   = 1'b0;
    endtask

    function automatic logic modelIrq();
        return mEn & ((mRxie & (mRxf | mOvr)) | (mTxie & mTxe));
    endfunction

    function automatic logic [7:0] modelRead(input logic [2:0] ad);
        case (ad)
            3'd0:    return mRxData;
            3'd1:    return {modelIrq(), 3'b000, ~mSsel, mOvr, mTxe, mRxf};
            3'd2:    return {5'b00000, mTxie, mRxie, mEn};
            default: return 8'h00;
        endcase
    endfunction

    task automatic modelWrite(input logic [2:0] ad, input logic [7:0] di);
        case (ad)
            3'd0: begin mTxHold = di; mTxe = 1'b0; end
            3'd1: if (di[2]) mOvr = 1'b0;
            3'd2: begin mEn = di[0]; mRxie = di[1]; mTxie = di[2]; end
            default: ;
        endcase
    endtask

    // The next byte to leave on miso: the pending hold byte if any, else idle fill.
    task automatic modelReload();
        if (!mTxe) begin
            mTxNext = mTxHold;
            mTxe    = 1'b1;
        end else begin
            mTxNext = 8'hFF;
        end
    endtask

    task automatic modelRxDone(input logic [7:0] b);
        if (!mRxf) begin
            mRxData = b;
            mRxf    = 1'b1;
        end else begin
            mOvr = 1'b1;
        end
    endtask

    task automatic busDrive(input logic isRead, input logic [2:0] ad, input logic [7:0] di);
        bus.AD = ad;
        bus.DI = di;
        bus.rw = isRead;
        bus.cs = 1'b1;
        tick(1);
        bus.cs = 1'b0;
        bus.rw = 1'b1;
        bus.AD = 3'd0;
        bus.DI = 8'h00;
    endtask

    task automatic applyStimulus(input logic isRead, input logic [2:0] ad, input logic [7:0] di);
        if (isRead) begin
            readQ.push_back(modelRead(ad));
            if (ad == 3'd0) mRxf = 1'b0;
        end else begin
            modelWrite(ad, di);
        end
        busDrive(isRead, ad, di);
        tick(1);
    endtask

    task automatic spiStart();
        ssel  = 1'b0;
        mSsel = 1'b0;
        if (mEn) modelReload();
        tick(6);
    endtask

    task automatic spiStop();
        ssel  = 1'b1;
        mSsel = 1'b1;
        tick(4);
    endtask

    // collide: 0 none, 1 DATA read on the 8th rising edge, 2 DATA write on the reload falling edge.
    task automatic spiByte(input logic [7:0] mo, input int nbits, input int collide, input logic [7:0] cdi);
        if (nbits == 8) misoQ.push_back(mTxNext);
        for (int i = 0; i < nbits; i++) begin
            mosi = mo[7-i];
            tick(HALF);
            sck = 1'b1;
            if (i == 7 && collide == 1) begin
                tick(2);
                readQ.push_back(mRxData);
                mRxData = mo;
                mRxf    = 1'b1;
                busDrive(1'b1, 3'd0, 8'h00);
                tick(HALF - 3);
            end else begin
                tick(HALF);
            end
            sck = 1'b0;
        end
        if (nbits == 8) begin
            if (collide != 1) modelRxDone(mo);
            if (collide == 2) begin
                tick(2);
                modelReload();
                modelWrite(3'd0, cdi);
                busDrive(1'b0, 3'd0, cdi);
                tick(2);
            end else begin
                modelReload();
                tick(4);
            end
        end else begin
            tick(4);
        end
    endtask

    // Monitor: checks every CPU read and every completed controller-side byte.
    always @(negedge clk) begin
        logic [7:0] exp;
        if (bus.cs && bus.rw) begin
            checks++;
            if (readQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL readUnexpected AD=%0d got %02h expected none", bus.AD, bus.DO);
            end else begin
                exp = readQ.pop_front();
                if (bus.DO !== exp) begin
                    errors++;
                    $display("[TB] FAIL readDO AD=%0d got %02h expected %02h at %0t", bus.AD, bus.DO, exp, $time);
                end
            end
        end
        if (ssel) begin
            misoCnt = 0;
        end else if (sck && !sckPrev) begin
            misoShift = {misoShift[6:0], miso};
            misoCnt++;
            if (misoCnt == 8) begin
                misoCnt = 0;
                checks++;
                if (misoQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL misoUnexpected got %02h expected none", misoShift);
                end else begin
                    exp = misoQ.pop_front();
                    if (misoShift !== exp) begin
                        errors++;
                        $display("[TB] FAIL misoByte got %02h expected %02h at %0t", misoShift, exp, $time);
                    end
                end
            end
        end
        sckPrev = sck;
    end

    initial begin
        #500000;
        errors++;
        $display("[TB] FAIL watchdog got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        logic [7:0] rb, b1, b2, b3, b4;
        int unsigned op, n;

        rst = 1'b0; ssel = 1'b1; sck = 1'b0; mosi = 1'b0;
        bus.cs = 1'b0; bus.rw = 1'b1; bus.AD = 3'd0; bus.DI = 8'h00;
        mSsel = 1'b1;
        modelReset();
        tick(3);
        checkOutput("rstIrq", 8'(bus.irq), 8'h00);
        checkOutput("rstMiso", 8'(miso), 8'h01);
        checkOutput("rstMisoOe", 8'(miso_oe), 8'h00);
        checkOutput("rstDo", bus.DO, 8'h00);
        rst = 1'b1;
        tick(3);

        applyStimulus(1'b1, 3'd1, 8'h00);
        applyStimulus(1'b1, 3'd2, 8'h00);
        applyStimulus(1'b1, 3'd0, 8'h00);
        rb = 8'($urandom);
        applyStimulus(1'b0, 3'd6, rb);
        applyStimulus(1'b1, 3'd6, 8'h00);
        applyStimulus(1'b1, 3'd7, 8'h00);
        checkOutput("doIdle", bus.DO, 8'h00);

        $display("[TB] basic transfer");
        applyStimulus(1'b0, 3'd2, 8'h01);
        applyStimulus(1'b0, 3'd0, 8'hA5);
        spiStart();
        checkOutput("oeActive", 8'(miso_oe), 8'h01);
        spiByte(8'h3C, 8, 0, 8'h00);
        applyStimulus(1'b1, 3'd1, 8'h00);
        applyStimulus(1'b1, 3'd0, 8'h00);
        applyStimulus(1'b1, 3'd1, 8'h00);
        spiStop();
        checkOutput("oeIdle", 8'(miso_oe), 8'h00);

        $display("[TB] underrun and overrun");
        b1 = 8'($urandom); b2 = 8'($urandom);
        spiStart();
        spiByte(b1, 8, 0, 8'h00);
        spiByte(b2, 8, 0, 8'h00);
        spiStop();
        applyStimulus(1'b1, 3'd1, 8'h00);
        applyStimulus(1'b1, 3'd0, 8'h00);
        applyStimulus(1'b0, 3'd1, 8'h04);
        applyStimulus(1'b1, 3'd1, 8'h00);

        $display("[TB] abort after 5 bits");
        rb = 8'($urandom);
        spiStart();
        spiByte(rb, 5, 0, 8'h00);
        spiStop();
        checkOutput("oeAbort", 8'(miso_oe), 8'h00);
        applyStimulus(1'b1, 3'd1, 8'h00);
        spiStart();
        spiByte(8'h81, 8, 0, 8'h00);
        spiStop();
        applyStimulus(1'b1, 3'd0, 8'h00);

        $display("[TB] interrupts");
        applyStimulus(1'b0, 3'd2, 8'h07);
        checkOutput("irqTxe", 8'(bus.irq), 8'(modelIrq()));
        rb = 8'($urandom);
        modelWrite(3'd0, rb);
        busDrive(1'b0, 3'd0, rb);
        checkOutput("irqLag", 8'(bus.irq), 8'h01);
        tick(1);
        checkOutput("irqWr", 8'(bus.irq), 8'(modelIrq()));
        applyStimulus(1'b0, 3'd2, 8'h03);
        spiStart();
        rb = 8'($urandom);
        spiByte(rb, 8, 0, 8'h00);
        checkOutput("irqRx", 8'(bus.irq), 8'(modelIrq()));
        spiStop();
        applyStimulus(1'b1, 3'd0, 8'h00);
        checkOutput("irqRd", 8'(bus.irq), 8'(modelIrq()));

        $display("[TB] collisions");
        b1 = 8'($urandom); b2 = 8'($urandom); b3 = 8'($urandom); b4 = 8'($urandom);
        spiStart();
        spiByte(b1, 8, 0, 8'h00);
        spiByte(b2, 8, 1, 8'h00);
        applyStimulus(1'b1, 3'd1, 8'h00);
        applyStimulus(1'b1, 3'd0, 8'h00);
        rb = 8'($urandom);
        applyStimulus(1'b0, 3'd0, rb);
        rb = 8'($urandom);
        spiByte(b3, 8, 2, rb);
        applyStimulus(1'b1, 3'd1, 8'h00);
        spiByte(b4, 8, 0, 8'h00);
        spiStop();
        applyStimulus(1'b1, 3'd1, 8'h00);
        applyStimulus(1'b1, 3'd0, 8'h00);

        $display("[TB] reset mid-byte");
        applyStimulus(1'b0, 3'd2, 8'h01);
        rb = 8'($urandom);
        applyStimulus(1'b0, 3'd0, rb);
        spiStart();
        rb = 8'($urandom);
        spiByte(rb, 3, 0, 8'h00);
        mosi = 1'b1;
        tick(HALF);
        sck = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        checkOutput("midRstIrq", 8'(bus.irq), 8'h00);
        checkOutput("midRstMiso", 8'(miso), 8'h01);
        checkOutput("midRstMisoOe", 8'(miso_oe), 8'h00);
        ssel = 1'b1; sck = 1'b0; mosi = 1'b0; mSsel = 1'b1;
        modelReset();
        tick(2);
        rst = 1'b1;
        tick(3);
        applyStimulus(1'b1, 3'd1, 8'h00);
        applyStimulus(1'b1, 3'd2, 8'h00);
        applyStimulus(1'b0, 3'd2, 8'h01);
        rb = 8'($urandom);
        applyStimulus(1'b0, 3'd0, rb);
        rb = 8'($urandom);
        spiStart();
        spiByte(rb, 8, 0, 8'h00);
        spiStop();
        applyStimulus(1'b1, 3'd0, 8'h00);

        $display("[TB] random operations");
        for (int k = 0; k < 40; k++) begin
            op = $urandom_range(0, 6);
            rb = 8'($urandom);
            case (op)
                0: applyStimulus(1'b0, 3'd0, rb);
                1: applyStimulus(1'b1, 3'd0, 8'h00);
                2: applyStimulus(1'b1, 3'd1, 8'h00);
                3: applyStimulus(1'b0, 3'd1, rb);
                4: begin
                    n = $urandom_range(1, 3);
                    spiStart();
                    for (int j = 0; j < int'(n); j++) begin
                        rb = 8'($urandom);
                        spiByte(rb, 8, 0, 8'h00);
                    end
                    spiStop();
                end
                5: applyStimulus(1'b1, 3'd2, 8'h00);
                default: applyStimulus(1'b0, 3'd2, {rb[7:1], 1'b1});
            endcase
        end
        applyStimulus(1'b1, 3'd1, 8'h00);

        tick(10);
        checks++;
        if (readQ.size() != 0 || misoQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL pendingQueues got %0d/%0d expected 0/0", readQ.size(), misoQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/spislaveio.md
SPISLAVEIO -- requirements
Module: spislaveio

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset; port names SHALL be clk and rst.
REQ-002 clk  in  1  system clock; all state SHALL change on its rising edge.
REQ-003 rst  in  1  asynchronous active-low reset.
REQ-004 irq  out  1  level interrupt request to the CPU, active high.
REQ-005 AD  in  3  register select.
REQ-006 DI  in  8  CPU write data.
REQ-007 DO  out  8  CPU read data.
REQ-008 rw  in  1  1 = read, 0 = write.
REQ-009 cs  in  1  chip select; already qualified with vma by the decoder.
REQ-010 ssel  in  1  SPI target select, active low, asynchronous to clk.
REQ-011 sck  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to clk.
REQ-012 mosi  in  1  serial data from the SPI controller.
REQ-013 miso  out  1  serial data to the SPI controller, MSB first.
REQ-014 miso_oe  out  1  output enable for the miso pad driver.

Function
REQ-015 ssel, sck and mosi SHALL each pass through a 2-flop synchronizer; edge detection SHALL use the synchronized value and its previous value.
REQ-016 The specified sck rate is at most clk/4; behaviour above that rate is undefined.
REQ-017 Register map:
- AD=0 DATA. Read returns RXDATA and clears RXF. Write loads TXHOLD and clears TXE.
- AD=1 STATUS. Bit0 RXF, bit1 TXE, bit2 OVR, bit3 BUSY (ssel low), bit7 = irq. Writing 1 to bit2 clears OVR; all other bits are read-only.
- AD=2 CTRL. Bit0 EN, bit1 RXIE, bit2 TXIE, bits 7:3 read as 0.
- AD=3..7 read 0x00; writes are ignored.
REQ-018 A write SHALL take effect at the rising clk edge when cs=1 and rw=0.
REQ-019 DO SHALL be combinational from AD while cs=1, and 0x00 otherwise.
REQ-020 A read side effect (RXF clear) SHALL occur at the rising clk edge when cs=1, rw=1 and AD=0.
REQ-021 The FSM SHALL have two states, IDLE and SHIFT.
REQ-022 IDLE -> SHIFT on a synchronized ssel falling edge while EN=1. On entry: bit counter := 0; TXSHIFT := TXHOLD and TXE := 1 if TXE=0, else TXSHIFT := 0xFF.
REQ-023 SHIFT -> IDLE on a synchronized ssel rising edge, or when EN is written 0. A partial byte SHALL be discarded, and RXF, OVR and RXDATA SHALL be left unchanged.
REQ-024 In SHIFT, on a synchronized sck rising edge: RXSHIFT := {RXSHIFT[6:0], mosi_sync}; counter increments modulo 8.
REQ-025 On the 8th sck rising edge of a byte:
- if RXF=0: RXDATA := the completed byte and RXF := 1;
- if RXF=1: the new byte is discarded and OVR := 1.
REQ-026 A DATA read in the same cycle as byte completion SHALL leave RXF=1 holding the new byte, with OVR unchanged.
REQ-027 In SHIFT, on a synchronized sck falling edge:
- counter != 0: TXSHIFT shifts left by one;
- counter == 0: TXSHIFT reloads from TXHOLD (TXE := 1), or from 0xFF if TXE=1.
REQ-028 A CPU DATA write in the same cycle as a TX reload SHALL be loaded into TXHOLD after the reload, leaving TXE=0.
REQ-029 A DATA write while TXE=0 SHALL overwrite TXHOLD with no error flag.
REQ-030 miso SHALL equal TXSHIFT[7]; miso_oe SHALL be 1 only in SHIFT with ssel_sync=0.
REQ-031 RXF SHALL be set 3 clk cycles after the sck pin rising edge (2 synchronizer stages plus 1 edge-detect register).
REQ-032 irq SHALL be computed as EN & ((RXIE & (RXF | OVR)) | (TXIE & TXE)), registered, so it follows the flags with 1 clk latency.

Reset
REQ-033 While rst=0:
- FSM = IDLE, counter = 0;
- RXDATA = 0x00, TXHOLD = 0x00, TXSHIFT = 0xFF;
- RXF = 0, OVR = 0, TXE = 1;
- CTRL = 0x00, irq = 0, miso = 1, miso_oe = 0;
- all synchronizer flops reset to ssel=1, sck=0, mosi=0.
REQ-034 Reset asserted mid-transfer SHALL abort it immediately. After release, the module SHALL wait in IDLE for a fresh ssel falling edge.

Verification
REQ-035 Basic transfer. CTRL=0x01, DATA write 0xA5, controller clocks 0x3C -> controller receives 0xA5; DATA read 0x3C; STATUS before the read 0x0B, after the read 0x0A with ssel low.
REQ-036 Underrun. No TX load, controller clocks 2 bytes -> miso shifts out 0xFF 0xFF; first byte in RXDATA; OVR=1 after the 2nd byte; write STATUS=0x04 -> OVR=0.
REQ-037 Abort. ssel deasserted after 5 bits -> RXF unchanged, miso_oe=0; the next full byte 0x81 is received correctly.
REQ-038 Interrupts. CTRL=0x07 -> irq=1 (TXE); DATA write -> irq=0 one cycle later; byte received -> irq=1; DATA read -> irq=0.
REQ-039 Collision. DATA read coincident with byte completion -> RXF=1 with the new byte, OVR=0. Separately, DATA write coincident with TX reload -> TXE=0.
REQ-040 Reset mid-byte. rst=0 pulse during bit 4 -> all outputs at REQ-033 values; the next transfer is received intact.
